switch_2x2_buffered: RTL and testbench

- Parametrised successor to the team's registered 2x2 switch element, used as the building block of the multistage interconnect network.
- Each input word carries a destination bit that routes it to the left or right output, instead of a single shared select.
- Inputs and outputs use valid/ready handshakes. Each output has a DEPTH-entry FIFO. Two inputs competing for one output are resolved by per-output round-robin arbitration.

---
 rtl/switch_2x2_buffered.sv | 134 +++++++++++++
 tb/tb_switch_2x2_buffered.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_2x2_buffered.sv
// Buffered 2x2 switch element: per-input holding registers, per-output FIFOs,
// destination-bit routing and per-output round-robin arbitration.
module switch_2x2_buffered #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] left_in_data,
  input  logic             left_in_dest,
  input  logic             left_in_valid,
  output logic             left_in_ready,
  input  logic [WIDTH-1:0] right_in_data,
  input  logic             right_in_dest,
  input  logic             right_in_valid,
  output logic             right_in_ready,
  output logic [WIDTH-1:0] left_out_data,
  output logic             left_out_valid,
  input  logic             left_out_ready,
  output logic [WIDTH-1:0] right_out_data,
  output logic             right_out_valid,
  input  logic             right_out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Index 0 is the left side, index 1 the right side, for inputs and outputs alike.
  logic [WIDTH-1:0] in_data  [2];
  logic [1:0]       in_valid;
  logic [1:0]       in_dest;
  logic [1:0]       in_ready;
  logic [1:0]       out_ready;

  logic [WIDTH-1:0] hold_data [2];
  logic [1:0]       hold_dest;
  logic [1:0]       hold_full;

  logic [WIDTH-1:0] mem    [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW:0]      count  [2];
  logic [1:0]       prio;

  logic [1:0] req [2];
  logic [1:0] move;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] win;
  logic [1:0] contested;

  assign in_data[0]   = left_in_data;
  assign in_data[1]   = right_in_data;
  assign in_valid     = {right_in_valid, left_in_valid};
  assign in_dest      = {right_in_dest, left_in_dest};
  assign out_ready    = {right_out_ready, left_out_ready};

  assign left_in_ready  = in_ready[0];
  assign right_in_ready = in_ready[1];

  assign left_out_data   = mem[0][rd_ptr[0]];
  assign right_out_data  = mem[1][rd_ptr[1]];
  assign left_out_valid  = (count[0] != '0);
  assign right_out_valid = (count[1] != '0);

  always_comb begin
    for (int o = 0; o < 2; o++) begin
      for (int i = 0; i < 2; i++) begin
        req[o][i] = hold_full[i] && (hold_dest[i] == 1'(o));
      end
    end
  end

  // Space is judged on the registered count only, so out_ready never reaches in_ready.
  always_comb begin
    move      = '0;
    push      = '0;
    win       = '0;
    contested = '0;
    for (int o = 0; o < 2; o++) begin
      if (count[o] < FULL_COUNT) begin
        contested[o] = &req[o];
        win[o]       = (&req[o]) ? prio[o] : req[o][1];
        push[o]      = |req[o];
        if (push[o]) begin
          move[win[o]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_ready[i] = rst_n && (!hold_full[i] || move[i]);
      pop[i]      = (count[i] != '0) && out_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        hold_full[k] <= 1'b0;
        wr_ptr[k]    <= '0;
        rd_ptr[k]    <= '0;
        count[k]     <= '0;
        prio[k]      <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          hold_data[i] <= in_data[i];
          hold_dest[i] <= in_dest[i];
          hold_full[i] <= 1'b1;
        end else if (move[i]) begin
          hold_full[i] <= 1'b0;
        end
      end
      for (int o = 0; o < 2; o++) begin
        if (push[o]) begin
          mem[o][wr_ptr[o]] <= hold_data[win[o]];
          wr_ptr[o]         <= wr_ptr[o] + 1'b1;
        end
        if (pop[o]) begin
          rd_ptr[o] <= rd_ptr[o] + 1'b1;
        end
        count[o] <= count[o] + (AW + 1)'(push[o]) - (AW + 1)'(pop[o]);
        if (contested[o]) begin
          prio[o] <= ~prio[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_2x2_buffered.sv
// Scoreboarded bench for switch_2x2_buffered; bit 15 of every word tags its source input.
module tb_switch_2x2_buffered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] left_in_data, right_in_data, left_out_data, right_out_data;
  logic        left_in_dest, left_in_valid, left_in_ready;
  logic        right_in_dest, right_in_valid, right_in_ready;
  logic        left_out_valid, left_out_ready, right_out_valid, right_out_ready;

  logic [15:0] w_left_in_data, w_right_in_data, w_left_out_data, w_right_out_data;
  logic        w_left_in_dest, w_left_in_valid, w_left_in_ready;
  logic        w_right_in_dest, w_right_in_valid, w_right_in_ready;
  logic        w_left_out_valid, w_left_out_ready, w_right_out_valid, w_right_out_ready;

  int tests = 0;
  int fails = 0;

  // Scoreboard queue index = instance*4 + source*2 + output.
  logic [15:0] sb [8][$];
  logic [15:0] lo_log [$];
  int          w_pops = 0;

  always #5 clk = ~clk;

  switch_2x2_buffered #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .left_in_data(left_in_data), .left_in_dest(left_in_dest),
    .left_in_valid(left_in_valid), .left_in_ready(left_in_ready),
    .right_in_data(right_in_data), .right_in_dest(right_in_dest),
    .right_in_valid(right_in_valid), .right_in_ready(right_in_ready),
    .left_out_data(left_out_data), .left_out_valid(left_out_valid),
    .left_out_ready(left_out_ready),
    .right_out_data(right_out_data), .right_out_valid(right_out_valid),
    .right_out_ready(right_out_ready)
  );

  switch_2x2_buffered #(.WIDTH(16), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .left_in_data(w_left_in_data), .left_in_dest(w_left_in_dest),
    .left_in_valid(w_left_in_valid), .left_in_ready(w_left_in_ready),
    .right_in_data(w_right_in_data), .right_in_dest(w_right_in_dest),
    .right_in_valid(w_right_in_valid), .right_in_ready(w_right_in_ready),
    .left_out_data(w_left_out_data), .left_out_valid(w_left_out_valid),
    .left_out_ready(w_left_out_ready),
    .right_out_data(w_right_out_data), .right_out_valid(w_right_out_valid),
    .right_out_ready(w_right_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input int inst, input int out, input logic [15:0] data);
    int idx;
    logic [15:0] exp;
    idx = inst * 4 + (data[15] ? 2 : 0) + out;
    exp = (sb[idx].size() > 0) ? sb[idx].pop_front() : 16'hxxxx;
    chk($sformatf("out%0d_%0d", inst, out), {16'h0, data}, {16'h0, exp});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) sb[k].delete();
    end else begin
      if (left_in_valid && left_in_ready) sb[0 + int'(left_in_dest)].push_back(left_in_data);
      if (right_in_valid && right_in_ready) sb[2 + int'(right_in_dest)].push_back(right_in_data);
      if (left_out_valid && left_out_ready) begin
        check_out(0, 0, left_out_data);
        lo_log.push_back(left_out_data);
      end
      if (right_out_valid && right_out_ready) check_out(0, 1, right_out_data);
      if (w_left_in_valid && w_left_in_ready) sb[4 + int'(w_left_in_dest)].push_back(w_left_in_data);
      if (w_left_out_valid && w_left_out_ready) begin
        check_out(1, 0, w_left_out_data);
        w_pops++;
      end
      if (w_right_out_valid && w_right_out_ready) check_out(1, 1, w_right_out_data);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int nl, input int nr, input logic dl, input logic dr,
                       input logic [15:0] bl, input logic [15:0] br,
                       input int budget, output int cyc);
    int il, ir;
    bit acc_l, acc_r;
    il = 0; ir = 0; cyc = 0;
    while ((il < nl || ir < nr) && cyc < budget) begin
      left_in_valid  = (il < nl);
      left_in_data   = bl + 16'(il);
      left_in_dest   = dl;
      right_in_valid = (ir < nr);
      right_in_data  = br + 16'(ir);
      right_in_dest  = dr;
      acc_l = left_in_valid && left_in_ready;
      acc_r = right_in_valid && right_in_ready;
      cycle();
      cyc++;
      if (acc_l) il++;
      if (acc_r) ir++;
    end
    left_in_valid  = 1'b0;
    right_in_valid = 1'b0;
  endtask

  task automatic drain(input int inst, input int budget);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
      if (inst == 0)
        done = (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() == 0)
               && !left_out_valid && !right_out_valid;
      else
        done = (sb[4].size() + sb[5].size() + sb[6].size() + sb[7].size() == 0)
               && !w_left_out_valid && !w_right_out_valid;
    end
    chk($sformatf("drain%0d", inst), 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;
    int wi;
    bit acc;
    logic [15:0] got;

    rst_n = 1'b0;
    left_in_data = '0; left_in_dest = 0; left_in_valid = 0;
    right_in_data = '0; right_in_dest = 0; right_in_valid = 0;
    left_out_ready = 1; right_out_ready = 1;
    w_left_in_data = '0; w_left_in_dest = 0; w_left_in_valid = 0;
    w_right_in_data = '0; w_right_in_dest = 0; w_right_in_valid = 0;
    w_left_out_ready = 1; w_right_out_ready = 1;

    // Reset state.
    cycle();
    cycle();
    chk("rst_lready", 32'(left_in_ready), 0);
    chk("rst_rready", 32'(right_in_ready), 0);
    chk("rst_lvalid", 32'(left_out_valid), 0);
    chk("rst_rvalid", 32'(right_out_valid), 0);
    rst_n = 1'b1;
    #1;
    chk("rel_lready", 32'(left_in_ready), 1);
    chk("rel_rready", 32'(right_in_ready), 1);

    // Straight routing: one word per cycle on each input.
    drive(4, 4, 1'b0, 1'b1, 16'h00A0, 16'h80B0, 20, cyc);
    chk("straight_cycles", 32'(cyc), 4);
    drain(0, 30);

    // Cross routing with two-cycle latency.
    left_in_valid = 1; left_in_data = 16'h0011; left_in_dest = 1;
    right_in_valid = 1; right_in_data = 16'h8022; right_in_dest = 0;
    chk("cross_lready", 32'(left_in_ready), 1);
    chk("cross_rready", 32'(right_in_ready), 1);
    cycle();
    left_in_valid = 0; right_in_valid = 0;
    chk("cross_lat1_l", 32'(left_out_valid), 0);
    chk("cross_lat1_r", 32'(right_out_valid), 0);
    cycle();
    chk("cross_rvalid", 32'(right_out_valid), 1);
    chk("cross_rdata", 32'(right_out_data), 32'h0011);
    chk("cross_lvalid", 32'(left_out_valid), 1);
    chk("cross_ldata", 32'(left_out_data), 32'h8022);
    drain(0, 20);

    // Contention on left_out: strict alternation starting with the left input.
    lo_log.delete();
    drive(4, 4, 1'b0, 1'b0, 16'h0010, 16'h8020, 40, cyc);
    drain(0, 30);
    chk("cont_count", 32'(lo_log.size()), 8);
    for (int i = 0; i < 8; i++) begin
      got = (lo_log.size() > i) ? lo_log[i] : 16'hxxxx;
      chk($sformatf("cont_order%0d", i), 32'(got),
          (i % 2 == 0) ? 32'h0010 + 32'(i / 2) : 32'h8020 + 32'(i / 2));
    end

    // Backpressure on right_out with a two-entry FIFO.
    right_out_ready = 0;
    drive(3, 0, 1'b1, 1'b0, 16'h00C0, 16'h0000, 20, cyc);
    chk("bp_cycles", 32'(cyc), 3);
    chk("bp_ready_low", 32'(left_in_ready), 0);
    chk("bp_valid", 32'(right_out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_stable", 32'(right_out_data), 32'h00C0);
      chk("bp_still_low", 32'(left_in_ready), 0);
    end
    right_out_ready = 1;
    drive(1, 0, 1'b1, 1'b0, 16'h00C3, 16'h0000, 20, cyc);
    drain(0, 30);

    // Reset mid-operation after a contested grant moved left_out priority to right.
    left_out_ready = 0; right_out_ready = 0;
    left_in_valid = 1; left_in_data = 16'h0050; left_in_dest = 0;
    right_in_valid = 1; right_in_data = 16'h8050; right_in_dest = 0;
    cycle();
    left_in_valid = 1; left_in_data = 16'h0051; left_in_dest = 1;
    right_in_valid = 0;
    cycle();
    left_in_valid = 0;
    cycle();
    rst_n = 0;
    #1;
    chk("midrst_lready", 32'(left_in_ready), 0);
    chk("midrst_rready", 32'(right_in_ready), 0);
    cycle();
    rst_n = 1;
    #1;
    chk("midrst_lvalid", 32'(left_out_valid), 0);
    chk("midrst_rvalid", 32'(right_out_valid), 0);
    chk("midrst_lready1", 32'(left_in_ready), 1);
    chk("midrst_rready1", 32'(right_in_ready), 1);
    left_out_ready = 1; right_out_ready = 1;
    lo_log.delete();
    drive(1, 1, 1'b0, 1'b0, 16'h0060, 16'h8060, 10, cyc);
    drain(0, 20);
    got = (lo_log.size() > 0) ? lo_log[0] : 16'hxxxx;
    chk("midrst_prio", 32'(got), 32'h0060);

    // Pointer wrap-around through a four-entry FIFO with random downstream stalls.
    wi = 0;
    cyc = 0;
    while (wi < 10 && cyc < 200) begin
      w_left_in_valid = 1;
      w_left_in_dest = 0;
      w_left_in_data = 16'h0100 + 16'(wi);
      w_left_out_ready = 1'($urandom_range(0, 1));
      acc = w_left_in_valid && w_left_in_ready;
      cycle();
      cyc++;
      if (acc) wi++;
    end
    w_left_in_valid = 0;
    w_left_out_ready = 1;
    chk("wrap_sent", 32'(wi), 10);
    drain(1, 40);
    chk("wrap_pops", 32'(w_pops), 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
